// File: rtl/reg_access_sched.sv
// rtl/reg_access_sched.sv - round-robin scheduler for the 8-bit register bank write path
// Optional RR_LOCK_EN: a locked winner keeps the grant while it holds req and req_lock.
module reg_access_sched #(
    parameter int NUM_REGS = 8,
    parameter int REG_AW   = 3,
    parameter int NUM_REQ  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic [REG_AW*NUM_REQ-1:0] req_dst,
    input  logic [REG_AW*NUM_REQ-1:0] req_src,
    input  logic [NUM_REQ-1:0]        req_lock,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REGS-1:0]       en_y,
    output logic                      wr,
    output logic                      clr,
    output logic [NUM_REGS-1:0]       en_s,
    output logic                      swp2,
    output logic [1:0]                bus3_sel,
    output logic [REG_AW-1:0]         bus5_sel,
    output logic                      busy,
    output logic                      err_op
);

    localparam logic [1:0] LAST_REQ = 2'(NUM_REQ - 1);
    localparam logic [2:0] NREQ3    = 3'(NUM_REQ);
    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_MOVE  = 2'b10;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_ptr;
    logic [1:0]            w_ptr_nxt;
    logic [1:0]            r_win;
    logic [1:0]            w_win_nxt;
    logic                  r_lock;
    logic                  w_lock_nxt;

    logic [NUM_REQ-1:0]    r_gnt,      w_gnt_nxt;
    logic [NUM_REGS-1:0]   r_en_y,     w_en_y_nxt;
    logic [NUM_REGS-1:0]   r_en_s,     w_en_s_nxt;
    logic                  r_wr,       w_wr_nxt;
    logic                  r_clr,      w_clr_nxt;
    logic                  r_swp2,     w_swp2_nxt;
    logic [1:0]            r_bus3_sel, w_bus3_sel_nxt;
    logic [REG_AW-1:0]     r_bus5_sel, w_bus5_sel_nxt;
    logic                  r_busy,     w_busy_nxt;
    logic                  r_err_op,   w_err_op_nxt;

    logic                  w_hold;
    logic [NUM_REQ-1:0]    w_cand;
    logic [1:0]            w_start;
    logic [2:0]            w_idx;
    logic                  w_found;
    logic [1:0]            w_sel;
    logic [1:0]            w_op;
    logic [REG_AW-1:0]     w_dst;
    logic [REG_AW-1:0]     w_src;
    logic                  w_bad;

`ifndef RR_LOCK_EN
    logic w_unused_lock;
    assign w_unused_lock = ^req_lock;
`endif

    // Candidate set and search start: the previous winner is masked unless its lock still holds.
    always_comb begin
        w_hold = 1'b0;
`ifdef RR_LOCK_EN
        w_hold = (r_state == S_ISSUE) && r_lock && req_lock[r_win] && req[r_win];
`endif
        w_cand  = req;
        w_start = r_ptr;
        if (r_state == S_ISSUE) begin
            if (w_hold) begin
                w_start = r_win;
            end else begin
                w_start = (r_win == LAST_REQ) ? 2'd0 : r_win + 2'd1;
                w_cand[r_win] = 1'b0;
            end
        end

        w_found = 1'b0;
        w_sel   = w_start;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = {1'b0, w_start} + 3'(i);
            if (w_idx >= NREQ3) begin
                w_idx = w_idx - NREQ3;
            end
            if (!w_found && w_cand[w_idx[1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[1:0];
            end
        end

        w_op  = req_op[2*w_sel +: 2];
        w_dst = req_dst[REG_AW*w_sel +: REG_AW];
        w_src = req_src[REG_AW*w_sel +: REG_AW];
        w_bad = (w_op == 2'b11)
             || (32'(w_dst) >= NUM_REGS)
             || ((w_op == OP_MOVE) && ((w_src == w_dst) || (32'(w_src) >= NUM_REGS)));
    end

    always_comb begin
        w_state_nxt    = S_IDLE;
        w_ptr_nxt      = (r_state == S_ISSUE) ? w_start : r_ptr;
        w_win_nxt      = r_win;
        w_lock_nxt     = 1'b0;
        w_gnt_nxt      = '0;
        w_en_y_nxt     = '0;
        w_en_s_nxt     = '0;
        w_wr_nxt       = 1'b0;
        w_clr_nxt      = 1'b0;
        w_swp2_nxt     = 1'b0;
        w_bus3_sel_nxt = r_bus3_sel;
        w_bus5_sel_nxt = r_bus5_sel;
        w_busy_nxt     = 1'b0;
        w_err_op_nxt   = 1'b0;

        if (w_found) begin
            w_state_nxt       = S_ISSUE;
            w_win_nxt         = w_sel;
            w_gnt_nxt[w_sel]  = 1'b1;
            w_busy_nxt        = 1'b1;
            w_bus3_sel_nxt    = w_sel;
`ifdef RR_LOCK_EN
            w_lock_nxt        = req_lock[w_sel];
`endif
            if (w_bad) begin
                w_err_op_nxt = 1'b1;
            end else begin
                case (w_op)
                    OP_WRITE: begin
                        w_en_y_nxt[w_dst] = 1'b1;
                        w_wr_nxt          = 1'b1;
                    end
                    OP_CLEAR: begin
                        w_en_y_nxt[w_dst] = 1'b1;
                        w_clr_nxt         = 1'b1;
                    end
                    OP_MOVE: begin
                        w_en_s_nxt[w_dst] = 1'b1;
                        w_swp2_nxt        = 1'b1;
                        w_bus5_sel_nxt    = w_src;
                    end
                    default: begin
                        w_err_op_nxt = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_win      <= '0;
            r_lock     <= 1'b0;
            r_gnt      <= '0;
            r_en_y     <= '0;
            r_en_s     <= '0;
            r_wr       <= 1'b0;
            r_clr      <= 1'b0;
            r_swp2     <= 1'b0;
            r_bus3_sel <= '0;
            r_bus5_sel <= '0;
            r_busy     <= 1'b0;
            r_err_op   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_win      <= w_win_nxt;
            r_lock     <= w_lock_nxt;
            r_gnt      <= w_gnt_nxt;
            r_en_y     <= w_en_y_nxt;
            r_en_s     <= w_en_s_nxt;
            r_wr       <= w_wr_nxt;
            r_clr      <= w_clr_nxt;
            r_swp2     <= w_swp2_nxt;
            r_bus3_sel <= w_bus3_sel_nxt;
            r_bus5_sel <= w_bus5_sel_nxt;
            r_busy     <= w_busy_nxt;
            r_err_op   <= w_err_op_nxt;
        end
    end

    assign gnt      = r_gnt;
    assign en_y     = r_en_y;
    assign en_s     = r_en_s;
    assign wr       = r_wr;
    assign clr      = r_clr;
    assign swp2     = r_swp2;
    assign bus3_sel = r_bus3_sel;
    assign bus5_sel = r_bus5_sel;
    assign busy     = r_busy;
    assign err_op   = r_err_op;

endmodule

// File: tb/tb_reg_access_sched.sv
// tb/tb_reg_access_sched.sv - scoreboard bench for reg_access_sched with a request-level reference model
module tb_reg_access_sched;

`ifdef RR_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [5:0] req_op;
    logic [8:0] req_dst;
    logic [8:0] req_src;
    logic [2:0] req_lock;
    logic [2:0] gnt;
    logic [7:0] en_y;
    logic       wr;
    logic       clr;
    logic [7:0] en_s;
    logic       swp2;
    logic [1:0] bus3_sel;
    logic [2:0] bus5_sel;
    logic       busy;
    logic       err_op;

    reg_access_sched #(.NUM_REGS(8), .REG_AW(3), .NUM_REQ(3)) dut (
        .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_dst(req_dst),
        .req_src(req_src), .req_lock(req_lock), .gnt(gnt), .en_y(en_y), .wr(wr),
        .clr(clr), .en_s(en_s), .swp2(swp2), .bus3_sel(bus3_sel), .bus5_sel(bus5_sel),
        .busy(busy), .err_op(err_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] gnt;
        logic [7:0] en_y;
        logic [7:0] en_s;
        logic       wr;
        logic       clr;
        logic       swp2;
        logic       err;
        logic [1:0] b3;
        logic [2:0] b5;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    int         m_ptr      = 0;
    int         m_last     = -1;
    bit         m_lastlock = 1'b0;
    int         m_win      = -1;
    logic [2:0] m_b5       = 3'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: who wins at this edge under round-robin from the pointer, and what that op should strobe.
    task automatic model_edge();
        exp_t       e;
        int         start;
        logic [2:0] cand;
        int         op;
        int         dst;
        int         src;
        m_win = -1;
        if (rst) begin
            m_ptr = 0; m_last = -1; m_lastlock = 1'b0; m_b5 = 3'd0;
            return;
        end
        cand  = req;
        start = m_ptr;
        if (m_last >= 0) begin
            if (LOCK_EN && m_lastlock && req_lock[m_last] && req[m_last]) begin
                start = m_last;
            end else begin
                start = (m_last + 1) % 3;
                cand[m_last] = 1'b0;
            end
            m_ptr = start;
        end
        for (int k = 0; k < 3; k++) begin
            if (m_win < 0 && cand[(start + k) % 3]) m_win = (start + k) % 3;
        end
        m_last = m_win;
        if (m_win < 0) return;
        m_lastlock = LOCK_EN && req_lock[m_win];
        op  = int'(req_op[2*m_win +: 2]);
        dst = int'(req_dst[3*m_win +: 3]);
        src = int'(req_src[3*m_win +: 3]);
        e.gnt = 3'b000; e.gnt[m_win] = 1'b1;
        e.en_y = 8'h00; e.en_s = 8'h00;
        e.wr = 1'b0; e.clr = 1'b0; e.swp2 = 1'b0; e.err = 1'b0;
        e.b3 = 2'(m_win);
        if (op == 3 || (op == 2 && src == dst)) begin
            e.err = 1'b1;
        end else if (op == 0) begin
            e.en_y = 8'h01 << dst; e.wr = 1'b1;
        end else if (op == 1) begin
            e.en_y = 8'h01 << dst; e.clr = 1'b1;
        end else begin
            e.en_s = 8'h01 << dst; e.swp2 = 1'b1; m_b5 = 3'(src);
        end
        e.b5 = m_b5;
        q.push_back(e);
    endtask

    task automatic tick_raw();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_req(input int i, input int op, input int dst, input int src, input int lk);
        req[i]          = 1'b1;
        req_op[2*i +: 2] = 2'(op);
        req_dst[3*i +: 3] = 3'(dst);
        req_src[3*i +: 3] = 3'(src);
        req_lock[i]     = lk[0];
    endtask

    task automatic new_op(input int i);
        int r;
        r = $urandom_range(0, 9);
        set_req(i, (r == 0) ? 3 : (r % 3), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1));
    endtask

    always @(negedge clk) begin
        if (gnt != 3'b000 || busy) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_grant: gnt=%b busy=%b with nothing expected at %0t", gnt, busy, $time);
            end else begin
                mon_e = q.pop_front();
                chk("gnt", 32'(gnt), 32'(mon_e.gnt));
                chk("busy", 32'(busy), 32'd1);
                chk("en_y", 32'(en_y), 32'(mon_e.en_y));
                chk("en_s", 32'(en_s), 32'(mon_e.en_s));
                chk("wr_clr_swp2", {29'd0, wr, clr, swp2}, {29'd0, mon_e.wr, mon_e.clr, mon_e.swp2});
                chk("err_op", 32'(err_op), 32'(mon_e.err));
                chk("bus3_sel", 32'(bus3_sel), 32'(mon_e.b3));
                chk("bus5_sel", 32'(bus5_sel), 32'(mon_e.b5));
            end
        end else begin
            chk("idle_outputs", {11'd0, q.size() != 0, en_y, en_s, wr, clr, swp2, err_op}, 32'd0);
        end
    end

    initial begin
        int r;
        rst = 1'b1; req = '0; req_op = '0; req_dst = '0; req_src = '0; req_lock = '0;
        repeat (3) tick_raw();
        rst = 1'b0;
        repeat (5) tick_raw();

        set_req(0, 0, 5, 0, 0); tick_raw(); req[0] = 1'b0; repeat (2) tick_raw();
        set_req(1, 2, 6, 2, 0); tick_raw(); req[1] = 1'b0; repeat (2) tick_raw();

        for (int rnd = 0; rnd < 2; rnd++) begin
            set_req(0, 1, 1, 0, 0); set_req(1, 1, 2, 0, 0); set_req(2, 1, 3, 0, 0);
            repeat (3) begin
                tick_raw();
                if (m_win >= 0) req[m_win] = 1'b0;
            end
            tick_raw();
        end

        set_req(2, 3, 1, 1, 0); tick_raw(); req[2] = 1'b0; tick_raw();
        set_req(2, 2, 4, 4, 0); tick_raw(); req[2] = 1'b0; tick_raw();

        set_req(0, 0, 5, 0, 0); tick_raw(); req[0] = 1'b0; rst = 1'b1;
        tick_raw(); rst = 1'b0; repeat (2) tick_raw();

        set_req(0, 0, 1, 0, 1); set_req(1, 1, 2, 0, 0);
        repeat (4) tick_raw();
        req_lock[0] = 1'b0;
        repeat (3) tick_raw();
        req = '0; repeat (2) tick_raw();

        for (int c = 0; c < 3000; c++) begin
            tick_raw();
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < 3; i++) begin
                if (i == m_win) begin
                    r = $urandom_range(0, 9);
                    if (r < 4) begin
                        if ($urandom_range(0, 1) == 0) req_lock[i] = 1'b0;
                    end else if (r < 7) begin
                        req[i] = 1'b0;
                    end else begin
                        new_op(i);
                    end
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    new_op(i);
                end
            end
        end

        rst = 1'b0; req = '0;
        repeat (3) tick_raw();
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
